// File: rtl/axil_pkg.sv
// axil_pkg: shared definitions for the AXI4-Lite RAM responder.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   w_state_t / r_state_t   : write and read channel FSM states
//   resp_for()              : maps an out-of-range flag to a response code
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    function automatic logic [1:0] resp_for(input logic out_of_range);
        return out_of_range ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_ram_responder_if.sv
// axil_ram_responder_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives valids/addresses/data and B/R readys
//   slave  modport : drives AW/W/AR readys and the B/R response channels
interface axil_ram_responder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

    logic [ADDR_WIDTH-1:0] s_axil_awaddr;
    logic [2:0]            s_axil_awprot;
    logic                  s_axil_awvalid;
    logic                  s_axil_awready;
    logic [DATA_WIDTH-1:0] s_axil_wdata;
    logic [STRB_WIDTH-1:0] s_axil_wstrb;
    logic                  s_axil_wvalid;
    logic                  s_axil_wready;
    logic [1:0]            s_axil_bresp;
    logic                  s_axil_bvalid;
    logic                  s_axil_bready;
    logic [ADDR_WIDTH-1:0] s_axil_araddr;
    logic [2:0]            s_axil_arprot;
    logic                  s_axil_arvalid;
    logic                  s_axil_arready;
    logic [DATA_WIDTH-1:0] s_axil_rdata;
    logic [1:0]            s_axil_rresp;
    logic                  s_axil_rvalid;
    logic                  s_axil_rready;

    modport master (
        output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        input  s_axil_awready,
        output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_wready,
        input  s_axil_bresp, s_axil_bvalid,
        output s_axil_bready,
        output s_axil_araddr, s_axil_arprot, s_axil_arvalid,
        input  s_axil_arready,
        input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output s_axil_rready
    );

    modport slave (
        input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        output s_axil_awready,
        input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_wready,
        output s_axil_bresp, s_axil_bvalid,
        input  s_axil_bready,
        input  s_axil_araddr, s_axil_arprot, s_axil_arvalid,
        output s_axil_arready,
        output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  s_axil_rready
    );

endinterface

// File: rtl/axil_ram_storage.sv
// axil_ram_storage: 2^DEPTH_LOG2-word RAM with two ports.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   a_we/a_widx/a_wdata/a_wstrb : port A byte-enable write
//   a_re/a_ridx/a_rzero/a_rdata : port A registered read (a_rzero forces 0)
//   b_we/b_widx/b_wdata         : port B full-word write
//   b_ridx/b_rdata              : port B combinational read
// Port A wins over port B when both write the same word on the same edge.
module axil_ram_storage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_we,
    input  logic [DEPTH_LOG2-1:0] a_widx,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [STRB_WIDTH-1:0] a_wstrb,
    input  logic                  a_re,
    input  logic [DEPTH_LOG2-1:0] a_ridx,
    input  logic                  a_rzero,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_we,
    input  logic [DEPTH_LOG2-1:0] b_widx,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic [DEPTH_LOG2-1:0] b_ridx,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Port B is written first so the later port A byte writes override it.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_widx] <= b_wdata;
        end
        if (a_we) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (a_wstrb[i]) begin
                    mem[a_widx][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
            end
        end
    end

    // The read samples mem before this edge's writes land: read-old-data.
    always_comb begin
        rdata_d = rdata_q;
        if (a_re) begin
            rdata_d = a_rzero ? '0 : mem[a_ridx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign a_rdata = rdata_q;
    assign b_rdata = mem[b_ridx];

endmodule

// File: rtl/axil_ram_responder.sv
// axil_ram_responder: AXI4-Lite slave backed by an on-chip word RAM.
//   clk, rst      : clock, synchronous active-high reset
//   s_axil        : AXI4-Lite slave bundle (single-beat reads/writes, byte strobes)
//   debug_addr    : debug read word index  -> debug_data = mem[debug_addr]
//   debug_wr_*    : debug full-word write port (AXI write wins on collision)
// Word index = addr[DEPTH_LOG2+1:2]; any set bit above that is out of range
// and answered with SLVERR (writes dropped, reads return 0).
// Debug word indices use only their low DEPTH_LOG2 bits.
// Optional build macro AXIL_RAM_CLEAR_EN: after reset, zero the whole RAM one
// word per cycle and hold all readys low until the sweep finishes.
module axil_ram_responder
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    axil_ram_responder_if.slave   s_axil,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    input  logic [ADDR_WIDTH-1:0] debug_wr_addr,
    input  logic [DATA_WIDTH-1:0] debug_wr_data,
    input  logic                  debug_wr_en
);

    // ---------------- write channel state ----------------
    w_state_t              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;

    // ---------------- read channel state -----------------
    r_state_t              r_state_q, r_state_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  clr_busy;
    logic                  aw_fire, w_fire, ar_fire;
    logic [ADDR_WIDTH-1:0] wr_addr_eff;
    logic [DATA_WIDTH-1:0] wr_data_eff;
    logic [STRB_WIDTH-1:0] wr_strb_eff;
    logic                  wr_oor, rd_oor;

    logic                  a_we;
    logic                  b_we;
    logic [DEPTH_LOG2-1:0] b_widx;
    logic [DATA_WIDTH-1:0] b_wdata;

    assign s_axil.s_axil_awready = !rst && !clr_busy && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_axil.s_axil_wready  = !rst && !clr_busy && (w_state_q == W_IDLE) && !w_held_q;
    assign s_axil.s_axil_arready = !rst && !clr_busy && (r_state_q == R_IDLE);
    assign s_axil.s_axil_bvalid  = (w_state_q == W_RESP);
    assign s_axil.s_axil_bresp   = bresp_q;
    assign s_axil.s_axil_rvalid  = (r_state_q == R_RESP);
    assign s_axil.s_axil_rresp   = rresp_q;

    assign aw_fire = s_axil.s_axil_awvalid && s_axil.s_axil_awready;
    assign w_fire  = s_axil.s_axil_wvalid  && s_axil.s_axil_wready;
    assign ar_fire = s_axil.s_axil_arvalid && s_axil.s_axil_arready;

    // A channel already latched supplies its stored beat; otherwise the beat
    // being accepted this cycle is used, so AW and W may arrive in any order.
    assign wr_addr_eff = aw_held_q ? awaddr_q : s_axil.s_axil_awaddr;
    assign wr_data_eff = w_held_q  ? wdata_q  : s_axil.s_axil_wdata;
    assign wr_strb_eff = w_held_q  ? wstrb_q  : s_axil.s_axil_wstrb;
    assign wr_oor      = |wr_addr_eff[ADDR_WIDTH-1:DEPTH_LOG2+2];
    assign rd_oor      = |s_axil.s_axil_araddr[ADDR_WIDTH-1:DEPTH_LOG2+2];

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        a_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axil.s_axil_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axil.s_axil_wdata;
                    wstrb_d  = s_axil.s_axil_wstrb;
                end
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    a_we      = !wr_oor;
                    bresp_d   = resp_for(wr_oor);
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil.s_axil_bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rresp_d   = resp_for(rd_oor);
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axil.s_axil_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rresp_q   <= rresp_d;
        end
    end

`ifdef AXIL_RAM_CLEAR_EN
    logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
    logic                  clr_busy_q, clr_busy_d;

    always_comb begin
        clr_cnt_d  = clr_cnt_q;
        clr_busy_d = clr_busy_q;
        if (clr_busy_q) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
                clr_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b1;
        end else begin
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // The sweep borrows port B; debug writes during the sweep are dropped.
    assign clr_busy = clr_busy_q;
    assign b_we     = clr_busy_q ? 1'b1 : debug_wr_en;
    assign b_widx   = clr_busy_q ? clr_cnt_q : debug_wr_addr[DEPTH_LOG2-1:0];
    assign b_wdata  = clr_busy_q ? '0 : debug_wr_data;
`else
    assign clr_busy = 1'b0;
    assign b_we     = debug_wr_en;
    assign b_widx   = debug_wr_addr[DEPTH_LOG2-1:0];
    assign b_wdata  = debug_wr_data;
`endif

    axil_ram_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .a_we    (a_we),
        .a_widx  (wr_addr_eff[DEPTH_LOG2+1:2]),
        .a_wdata (wr_data_eff),
        .a_wstrb (wr_strb_eff),
        .a_re    (ar_fire),
        .a_ridx  (s_axil.s_axil_araddr[DEPTH_LOG2+1:2]),
        .a_rzero (rd_oor),
        .a_rdata (s_axil.s_axil_rdata),
        .b_we    (b_we),
        .b_widx  (b_widx),
        .b_wdata (b_wdata),
        .b_ridx  (debug_addr[DEPTH_LOG2-1:0]),
        .b_rdata (debug_data)
    );

    // Byte-lane address bits, protection fields and high debug index bits
    // carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wr_addr_eff[1:0], s_axil.s_axil_araddr[1:0],
                           s_axil.s_axil_awprot, s_axil.s_axil_arprot,
                           debug_addr[ADDR_WIDTH-1:DEPTH_LOG2],
                           debug_wr_addr[ADDR_WIDTH-1:DEPTH_LOG2]};

endmodule

// File: tb/tb_axil_ram_responder.sv
// tb_axil_ram_responder: randomized scoreboard bench for axil_ram_responder.
// A word-array reference model predicts every B and R response at issue time;
// a negedge monitor pops and compares on each B/R handshake.
module tb_axil_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] debug_addr = '0;
    logic [31:0] debug_data;
    logic [15:0] debug_wr_addr = '0;
    logic [31:0] debug_wr_data = '0;
    logic        debug_wr_en = 1'b0;

    axil_ram_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    axil_ram_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .DEPTH_LOG2 (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil        (bus),
        .debug_addr    (debug_addr),
        .debug_data    (debug_data),
        .debug_wr_addr (debug_wr_addr),
        .debug_wr_data (debug_wr_data),
        .debug_wr_en   (debug_wr_en)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [256];
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_range(input logic [15:0] addr);
        return addr < 16'h0400;
    endfunction

    function automatic void model_write(input logic [15:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        if (!in_range(addr)) begin
            exp_b.push_back(2'b10);
        end else begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr / 4][8*b +: 8] = data[8*b +: 8];
            exp_b.push_back(2'b00);
        end
    endfunction

    function automatic void model_read(input logic [15:0] addr);
        if (!in_range(addr)) exp_r.push_back({2'b10, 32'h0});
        else                 exp_r.push_back({2'b00, ref_mem[addr / 4]});
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s_axil_bvalid && bus.s_axil_bready) begin
                if (exp_b.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", {62'h0, bus.s_axil_bresp}, {62'h0, exp_b.pop_front()});
            end
            if (bus.s_axil_rvalid && bus.s_axil_rready) begin
                if (exp_r.size() == 0) check("r_unexpected", 1, 0);
                else check("rresp_rdata", {30'h0, bus.s_axil_rresp, bus.s_axil_rdata},
                           {30'h0, exp_r.pop_front()});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input logic [7:0] idx, input logic [31:0] data);
        debug_wr_en = 1'b1;
        debug_wr_addr = {8'h0, idx};
        debug_wr_data = data;
        ref_mem[idx] = data;
        tick();
        debug_wr_en = 1'b0;
    endtask

    task automatic dbg_check(input logic [7:0] idx);
        debug_addr = {8'h0, idx};
        #1;
        check("debug_data", {32'h0, debug_data}, {32'h0, ref_mem[idx]});
    endtask

    task automatic drain();
        int n = 0;
        bus.s_axil_bready = 1'b1;
        bus.s_axil_rready = 1'b1;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("drain_timeout", 1, 0);
        bus.s_axil_bready = 1'b0;
        bus.s_axil_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        model_write(addr, data, strb);
        bus.s_axil_awaddr = addr;
        bus.s_axil_awprot = 3'($urandom);
        bus.s_axil_wdata  = data;
        bus.s_axil_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            bus.s_axil_awvalid = !aw_done && cyc >= aw_dly;
            bus.s_axil_wvalid  = !w_done && cyc >= w_dly;
            @(negedge clk);
            hs_aw = bus.s_axil_awvalid && bus.s_axil_awready;
            hs_w  = bus.s_axil_wvalid && bus.s_axil_wready;
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            cyc++;
        end
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid  = 1'b0;
        if (cyc >= 100) check("aw_w_timeout", 1, 0);
        repeat (b_dly) tick();
        drain();
    endtask

    task automatic axi_read(input logic [15:0] addr, input int r_dly);
        bit hs = 0;
        int cyc = 0;
        model_read(addr);
        bus.s_axil_araddr = addr;
        bus.s_axil_arprot = 3'($urandom);
        bus.s_axil_arvalid = 1'b1;
        while (!hs && cyc < 100) begin
            @(negedge clk);
            hs = bus.s_axil_arvalid && bus.s_axil_arready;
            tick();
            cyc++;
        end
        bus.s_axil_arvalid = 1'b0;
        if (!hs) check("ar_timeout", 1, 0);
        repeat (r_dly) tick();
        drain();
    endtask

    task automatic wait_ready(output int lows);
        lows = 0;
        while (lows < 400) begin
            @(negedge clk);
            if (bus.s_axil_arready) break;
            lows++;
        end
        tick();
        if (lows >= 400) check("ready_timeout", 1, 0);
    endtask

    initial begin
        int lows;
        logic [15:0] a;
        bus.s_axil_awaddr = '0; bus.s_axil_awprot = '0; bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata = '0;  bus.s_axil_wstrb = '0;  bus.s_axil_wvalid = 1'b0;
        bus.s_axil_bready = 1'b0;
        bus.s_axil_araddr = '0; bus.s_axil_arprot = '0; bus.s_axil_arvalid = 1'b0;
        bus.s_axil_rready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", {61'h0, bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}, 0);
        check("rst_valid", {62'h0, bus.s_axil_bvalid, bus.s_axil_rvalid}, 0);
        check("rst_resp_data", {28'h0, bus.s_axil_bresp, bus.s_axil_rresp, bus.s_axil_rdata}, 0);
        tick();
        rst = 1'b0;
        wait_ready(lows);
`ifdef AXIL_RAM_CLEAR_EN
        check("clear_low_cycles", lows, 256);
`else
        check("ready_after_rst", lows, 0);
`endif
        for (int i = 0; i < 256; i++) dbg_write(8'(i), $urandom);

        // Basic write then read
        axi_write(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        axi_read(16'h0010, 0);
        dbg_check(8'd4);

        // Byte strobes over debug-preloaded word
        dbg_write(8'd5, 32'h11223344);
        axi_write(16'h0014, 32'hAABBCCDD, 4'h5, 1, 0, 1);
        axi_read(16'h0014, 2);
        debug_addr = 16'd5;
        #1 check("strobe_merge", {32'h0, debug_data}, 64'h11BB33DD);

        // AW first, W three cycles later, B stalled four cycles
        model_write(16'h0030, 32'hCAFEF00D, 4'hF);
        bus.s_axil_awaddr = 16'h0030; bus.s_axil_wdata = 32'hCAFEF00D; bus.s_axil_wstrb = 4'hF;
        bus.s_axil_awvalid = 1'b1;
        tick();
        bus.s_axil_awvalid = 1'b0;
        repeat (2) begin
            check("aw_held_ready", {63'h0, bus.s_axil_awready}, 0);
            check("b_not_early", {63'h0, bus.s_axil_bvalid}, 0);
            tick();
        end
        bus.s_axil_wvalid = 1'b1;
        #1 check("w_ready", {63'h0, bus.s_axil_wready}, 1);
        tick();
        bus.s_axil_wvalid = 1'b0;
        repeat (4) begin
            check("b_stall_valid", {63'h0, bus.s_axil_bvalid}, 1);
            check("b_stall_awready", {63'h0, bus.s_axil_awready}, 0);
            tick();
        end
        drain();

        // Out of range
        axi_read(16'h0400, 0);
        axi_write(16'h0400, 32'h12345678, 4'hF, 0, 0, 0);
        dbg_check(8'd0);

        // Same-edge read and write to one word: read sees old data
        dbg_write(8'd8, 32'h1);
        model_read(16'h0020);
        model_write(16'h0020, 32'h2, 4'hF);
        bus.s_axil_awaddr = 16'h0020; bus.s_axil_wdata = 32'h2; bus.s_axil_wstrb = 4'hF;
        bus.s_axil_araddr = 16'h0020;
        bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; bus.s_axil_arvalid = 1'b1;
        @(negedge clk);
        check("rw_readys", {61'h0, bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}, 7);
        tick();
        bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0; bus.s_axil_arvalid = 1'b0;
        drain();
        axi_read(16'h0020, 0);

        // Debug and AXI write collide: same word, then different words
        for (int k = 0; k < 2; k++) begin
            logic [7:0] didx;
            didx = (k == 0) ? 8'd9 : 8'd10;
            debug_wr_en = 1'b1; debug_wr_addr = {8'h0, didx}; debug_wr_data = 32'h55555555;
            ref_mem[didx] = 32'h55555555;
            model_write(16'h0024, 32'h99999999 + k, 4'hF);
            bus.s_axil_awaddr = 16'h0024; bus.s_axil_wdata = 32'h99999999 + k; bus.s_axil_wstrb = 4'hF;
            bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1;
            tick();
            debug_wr_en = 1'b0; bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
            drain();
            dbg_check(8'd9);
            dbg_check(8'd10);
        end

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h0400, 16'hFFFF));
            else a = 16'($urandom_range(0, 16'h03FF));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 3));
            if (t % 8 == 0) dbg_check(8'($urandom));
        end

        // Reset while R is stalled
        bus.s_axil_araddr = 16'h0014; bus.s_axil_arvalid = 1'b1;
        tick();
        bus.s_axil_arvalid = 1'b0;
        tick();
        check("r_pending", {63'h0, bus.s_axil_rvalid}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", {61'h0, bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}, 0);
        tick();
        check("rvalid_after_rst", {63'h0, bus.s_axil_rvalid}, 0);
        check("rdata_after_rst", {32'h0, bus.s_axil_rdata}, 0);
        tick();
        rst = 1'b0;
        wait_ready(lows);
`ifdef AXIL_RAM_CLEAR_EN
        check("clear_low_cycles_2", lows, 256);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
`else
        check("ready_after_rst_2", lows, 0);
`endif
        axi_read(16'h0014, 0);
        dbg_check(8'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
